turn_scheduler: RTL and testbench

TURN_SCHEDULER -- requirements
Module: turn_scheduler

---
 rtl/turn_scheduler.sv | 127 ++++++++++++
 tb/tb_turn_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/turn_scheduler.sv
// rtl/turn_scheduler.sv - turn, timer and lives sequencer for a two-player artillery game
module turn_scheduler #(
  parameter int TURN_FRAMES = 600,
  parameter int LIVES       = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       shot_done,
  input  logic       hit,
  output logic [1:0] currentState,
  output logic       activePlayer,
  output logic       fire_start,
  output logic [9:0] turnTimer,
  output logic [1:0] lives0,
  output logic [1:0] lives1,
  output logic       winner
);

  localparam logic [7:0] KEY_ENTER    = 8'h28;
  localparam logic [7:0] KEY_SPACE    = 8'h2C;
  localparam logic [9:0] TIMER_RELOAD = 10'(TURN_FRAMES);
  localparam logic [1:0] LIVES_INIT   = 2'(LIVES);

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    AIM    = 2'd1,
    FIRE   = 2'd2,
    OVER   = 2'd3
  } phaseT;

  phaseT      state, stateNext;
  logic [7:0] prevKey;
  logic       playerNext, fireNext, winnerNext;
  logic [9:0] timerNext;
  logic [1:0] lives0Next, lives1Next;
  logic       keyPress, enterPress, spacePress;
  logic [1:0] oppLives, oppLivesDec;

  // Only the 0x00 -> non-zero transition acts, so a held key fires once.
  assign keyPress    = (prevKey == 8'h00) && (keycode != 8'h00);
  assign enterPress  = keyPress && (keycode == KEY_ENTER);
  assign spacePress  = keyPress && (keycode == KEY_SPACE);
  assign oppLives    = activePlayer ? lives0 : lives1;
  assign oppLivesDec = (oppLives == 2'd0) ? 2'd0 : oppLives - 2'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= SELECT;
      prevKey      <= 8'h00;
      activePlayer <= 1'b0;
      fire_start   <= 1'b0;
      turnTimer    <= 10'd0;
      lives0       <= LIVES_INIT;
      lives1       <= LIVES_INIT;
      winner       <= 1'b0;
    end else begin
      state        <= stateNext;
      prevKey      <= keycode;
      activePlayer <= playerNext;
      fire_start   <= fireNext;
      turnTimer    <= timerNext;
      lives0       <= lives0Next;
      lives1       <= lives1Next;
      winner       <= winnerNext;
    end
  end

  always_comb begin
    stateNext  = state;
    playerNext = activePlayer;
    fireNext   = 1'b0;
    timerNext  = turnTimer;
    lives0Next = lives0;
    lives1Next = lives1;
    winnerNext = winner;
    case (state)
      SELECT: begin
        if (enterPress) begin
          stateNext  = AIM;
          playerNext = 1'b0;
          timerNext  = TIMER_RELOAD;
          lives0Next = LIVES_INIT;
          lives1Next = LIVES_INIT;
        end
      end
      AIM: begin
        // Firing wins over a timeout landing on the same cycle.
        if (spacePress) begin
          stateNext = FIRE;
          fireNext  = 1'b1;
        end else if (frame_tick) begin
          if (turnTimer == 10'd1) begin
            playerNext = ~activePlayer;
            timerNext  = TIMER_RELOAD;
          end else begin
            timerNext = turnTimer - 10'd1;
          end
        end
      end
      FIRE: begin
        if (shot_done) begin
          if (hit) begin
            if (activePlayer) lives0Next = oppLivesDec;
            else              lives1Next = oppLivesDec;
          end
          if (hit && oppLivesDec == 2'd0) begin
            stateNext  = OVER;
            winnerNext = activePlayer;
          end else begin
            stateNext  = AIM;
            playerNext = ~activePlayer;
            timerNext  = TIMER_RELOAD;
          end
        end
      end
      OVER: begin
        if (enterPress) stateNext = SELECT;
      end
      default: stateNext = SELECT;
    endcase
  end

  assign currentState = state;

endmodule

// File: tb/tb_turn_scheduler.sv
// tb/tb_turn_scheduler.sv - directed and randomized checks of turn_scheduler against a game-rule model
module tb_turn_scheduler;

  localparam int TF = 4;
  localparam int LV = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       shot_done = 1'b0;
  logic       hit = 1'b0;
  logic [1:0] currentState;
  logic       activePlayer;
  logic       fire_start;
  logic [9:0] turnTimer;
  logic [1:0] lives0;
  logic [1:0] lives1;
  logic       winner;

  int testCount = 0;
  int errorCount = 0;
  int fireCount;

  // Game-level model: phase 0..3, player index, frames left, lives per player.
  int mPhase, mPlayer, mTimer, mWinner, mFire, mPrevKey;
  int mLives[2];

  turn_scheduler #(.TURN_FRAMES(TF), .LIVES(LV)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .shot_done(shot_done), .hit(hit), .currentState(currentState),
    .activePlayer(activePlayer), .fire_start(fire_start), .turnTimer(turnTimer),
    .lives0(lives0), .lives1(lives1), .winner(winner)
  );

  always #5 Clk = ~Clk;

  task automatic checkValue(input string tag, input int observed, input int expected);
    testCount++;
    if (observed != expected) begin
      errorCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mPhase = 0; mPlayer = 0; mTimer = 0; mWinner = 0; mFire = 0; mPrevKey = 0;
    mLives[0] = LV; mLives[1] = LV;
  endtask

  task automatic modelStep();
    bit press;
    int opp;
    press = (mPrevKey == 0) && (keycode != 8'h00);
    opp = 1 - mPlayer;
    mFire = 0;
    if (mPhase == 0) begin
      if (press && keycode == 8'h28) begin
        mPhase = 1; mPlayer = 0; mTimer = TF; mLives[0] = LV; mLives[1] = LV;
      end
    end else if (mPhase == 1) begin
      if (press && keycode == 8'h2C) begin
        mPhase = 2; mFire = 1;
      end else if (frame_tick) begin
        mTimer = mTimer - 1;
        if (mTimer == 0) begin
          mPlayer = opp; mTimer = TF;
        end
      end
    end else if (mPhase == 2) begin
      if (shot_done) begin
        if (hit && mLives[opp] > 0) mLives[opp] = mLives[opp] - 1;
        if (hit && mLives[opp] == 0) begin
          mPhase = 3; mWinner = mPlayer;
        end else begin
          mPhase = 1; mPlayer = opp; mTimer = TF;
        end
      end
    end else begin
      if (press && keycode == 8'h28) mPhase = 0;
    end
    mPrevKey = keycode;
  endtask

  // Inputs are driven before this call; outputs are valid on return (negedge).
  task automatic stepCycle();
    if (Reset) modelReset();
    @(posedge Clk);
    if (Reset) modelReset();
    else modelStep();
    @(negedge Clk);
  endtask

  task automatic checkAll(input string tag);
    checkValue({tag, ".state"},  currentState, mPhase);
    checkValue({tag, ".player"}, activePlayer, mPlayer);
    checkValue({tag, ".fire"},   fire_start,   mFire);
    checkValue({tag, ".timer"},  turnTimer,    mTimer);
    checkValue({tag, ".lives0"}, lives0,       mLives[0]);
    checkValue({tag, ".lives1"}, lives1,       mLives[1]);
    checkValue({tag, ".winner"}, winner,       mWinner);
  endtask

  initial begin
    modelReset();
    @(negedge Clk);
    Reset = 1'b1;
    stepCycle();
    stepCycle();
    Reset = 1'b0;
    checkValue("rst.state", currentState, 0);
    checkValue("rst.player", activePlayer, 0);
    checkValue("rst.fire", fire_start, 0);
    checkValue("rst.timer", turnTimer, 0);
    checkValue("rst.lives0", lives0, LV);
    checkValue("rst.lives1", lives1, LV);
    checkValue("rst.winner", winner, 0);

    // Start
    keycode = 8'h00; stepCycle();
    keycode = 8'h28; stepCycle();
    checkValue("start.state", currentState, 1);
    checkValue("start.player", activePlayer, 0);
    checkValue("start.timer", turnTimer, TF);
    checkValue("start.lives0", lives0, LV);
    checkValue("start.lives1", lives1, LV);
    keycode = 8'h00; stepCycle();

    // Timeout
    frame_tick = 1'b1;
    stepCycle(); checkValue("tmo.t3", turnTimer, 3);
    stepCycle(); checkValue("tmo.t2", turnTimer, 2);
    stepCycle(); checkValue("tmo.t1", turnTimer, 1);
    stepCycle();
    checkValue("tmo.player", activePlayer, 1);
    checkValue("tmo.reload", turnTimer, TF);
    checkValue("tmo.state", currentState, 1);
    frame_tick = 1'b0;

    // Held Space fires once
    keycode = 8'h2C;
    fireCount = 0;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      if (i == 0) begin
        checkValue("held.state", currentState, 2);
        checkValue("held.fire", fire_start, 1);
      end
      fireCount += int'(fire_start);
    end
    checkValue("held.pulses", fireCount, 1);
    keycode = 8'h00; stepCycle();
    shot_done = 1'b1; hit = 1'b0; stepCycle();
    shot_done = 1'b0;
    checkValue("miss.state", currentState, 1);
    checkValue("miss.player", activePlayer, 0);
    checkValue("miss.timer", turnTimer, TF);
    fireCount = 0;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      fireCount += int'(fire_start);
    end
    checkValue("miss.nofire", fireCount, 0);

    // Collision: Space on the expiring frame_tick
    frame_tick = 1'b1;
    stepCycle(); stepCycle(); stepCycle();
    checkValue("col.t1", turnTimer, 1);
    keycode = 8'h2C; stepCycle();
    frame_tick = 1'b0; keycode = 8'h00;
    checkValue("col.state", currentState, 2);
    checkValue("col.fire", fire_start, 1);
    checkValue("col.player", activePlayer, 0);
    checkValue("col.timer", turnTimer, 1);

    // Win: player 0 hits twice
    shot_done = 1'b1; hit = 1'b1; stepCycle();
    shot_done = 1'b0; hit = 1'b0;
    checkValue("win.lives1a", lives1, 1);
    checkValue("win.player1", activePlayer, 1);
    keycode = 8'h2C; stepCycle();
    keycode = 8'h00; shot_done = 1'b1; stepCycle();
    shot_done = 1'b0;
    checkValue("win.back0", activePlayer, 0);
    keycode = 8'h2C; stepCycle();
    keycode = 8'h00; shot_done = 1'b1; hit = 1'b1; stepCycle();
    shot_done = 1'b0; hit = 1'b0;
    checkValue("win.lives1b", lives1, 0);
    checkValue("win.lives0", lives0, LV);
    checkValue("win.state", currentState, 3);
    checkValue("win.winner", winner, 0);
    keycode = 8'h28; stepCycle();
    keycode = 8'h00;
    checkValue("over.state", currentState, 0);
    checkValue("over.lives1", lives1, 0);
    checkValue("over.winner", winner, 0);
    stepCycle();

    // Reset mid-FIRE
    keycode = 8'h28; stepCycle();
    keycode = 8'h00; stepCycle();
    keycode = 8'h2C; stepCycle();
    keycode = 8'h00;
    checkValue("rfire.state", currentState, 2);
    Reset = 1'b1; stepCycle();
    Reset = 1'b0;
    shot_done = 1'b1; hit = 1'b1; stepCycle();
    shot_done = 1'b0; hit = 1'b0;
    checkValue("rfire.state0", currentState, 0);
    checkValue("rfire.lives0", lives0, LV);
    checkValue("rfire.lives1", lives1, LV);
    checkValue("rfire.fire", fire_start, 0);
    checkAll("post");

    // Randomized play against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(2) == 0) begin
        case ($urandom_range(5))
          0, 1: keycode = 8'h00;
          2:    keycode = 8'h28;
          3, 4: keycode = 8'h2C;
          default: keycode = 8'h04;
        endcase
      end
      frame_tick = ($urandom_range(2) == 0);
      shot_done  = ($urandom_range(5) == 0);
      hit        = $urandom_range(1) == 1;
      Reset      = ($urandom_range(299) == 0);
      stepCycle();
      checkAll("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, errorCount);
    $finish;
  end

endmodule
